// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - two-source register-file writeback arbiter with starvation guard (optional WB_R0_DISCARD_EN)
module writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              load_enable,
  output logic [ADDR_W-1:0] rc,
  output logic [DATA_W-1:0] ry,
  output logic [15:0]       wb_count
);

  typedef enum logic {MEM_PRI = 1'b0, ALU_PRI = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_alu_full;
  logic              r_mem_full;
  logic [ADDR_W-1:0] r_alu_rd;
  logic [ADDR_W-1:0] r_mem_rd;
  logic [DATA_W-1:0] r_alu_data;
  logic [DATA_W-1:0] r_mem_data;
  logic [1:0]        r_starve;
  logic              r_load_enable;
  logic [ADDR_W-1:0] r_rc;
  logic [DATA_W-1:0] r_ry;
  logic [15:0]       r_wb_count;

  logic              w_grant_alu;
  logic              w_grant_mem;
  logic              w_grant_any;
  logic              w_alu_xfer;
  logic              w_mem_xfer;
  logic              w_alu_starving;
  logic              w_write;
  logic [ADDR_W-1:0] w_drain_rd;
  logic [DATA_W-1:0] w_drain_data;

  // Grant the priority slot if full, otherwise the other one; choose next priority mode
  always_comb begin
    w_next_state = r_state;
    w_grant_alu  = 1'b0;
    w_grant_mem  = 1'b0;
    case (r_state)
      MEM_PRI: begin
        if (r_mem_full)      w_grant_mem = 1'b1;
        else if (r_alu_full) w_grant_alu = 1'b1;
        // Second consecutive starved cycle flips priority toward the ALU slot
        if (r_alu_full && !w_grant_alu && (r_starve == 2'd1)) w_next_state = ALU_PRI;
      end
      ALU_PRI: begin
        if (r_alu_full)      w_grant_alu = 1'b1;
        else if (r_mem_full) w_grant_mem = 1'b1;
        if (w_grant_alu) w_next_state = MEM_PRI;
      end
      default: w_next_state = MEM_PRI;
    endcase
  end

  assign w_grant_any    = w_grant_alu | w_grant_mem;
  assign w_alu_starving = r_alu_full & ~w_grant_alu;
  assign w_drain_rd     = w_grant_alu ? r_alu_rd   : r_mem_rd;
  assign w_drain_data   = w_grant_alu ? r_alu_data : r_mem_data;

  // A slot accepts when empty or being drained this cycle; held off entirely during reset
  assign alu_ready  = rst_n & (~r_alu_full | w_grant_alu);
  assign mem_ready  = rst_n & (~r_mem_full | w_grant_mem);
  assign w_alu_xfer = alu_valid & alu_ready;
  assign w_mem_xfer = mem_valid & mem_ready;

`ifdef WB_R0_DISCARD_EN
  assign w_write = w_grant_any & (w_drain_rd != '0);
`else
  assign w_write = w_grant_any;
`endif

  // Priority FSM state and ALU starvation counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= MEM_PRI;
      r_starve <= 2'd0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_alu)                            r_starve <= 2'd0;
      else if (w_alu_starving && r_starve != 2'd3) r_starve <= r_starve + 2'd1;
    end
  end

  // Holding slots: refill wins over drain so a same-cycle drain+load stays full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_full <= 1'b0;
      r_mem_full <= 1'b0;
      r_alu_rd   <= '0;
      r_alu_data <= '0;
      r_mem_rd   <= '0;
      r_mem_data <= '0;
    end else begin
      if (w_alu_xfer) begin
        r_alu_full <= 1'b1;
        r_alu_rd   <= alu_rd;
        r_alu_data <= alu_data;
      end else if (w_grant_alu) begin
        r_alu_full <= 1'b0;
      end
      if (w_mem_xfer) begin
        r_mem_full <= 1'b1;
        r_mem_rd   <= mem_rd;
        r_mem_data <= mem_data;
      end else if (w_grant_mem) begin
        r_mem_full <= 1'b0;
      end
    end
  end

  // Registered register-file write port and write counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_enable <= 1'b0;
      r_rc          <= '0;
      r_ry          <= '0;
      r_wb_count    <= 16'd0;
    end else begin
      r_load_enable <= w_write;
      if (w_write) begin
        r_rc       <= w_drain_rd;
        r_ry       <= w_drain_data;
        r_wb_count <= r_wb_count + 16'd1;
      end
    end
  end

  assign load_enable = r_load_enable;
  assign rc          = r_rc;
  assign ry          = r_ry;
  assign wb_count    = r_wb_count;

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width (32 registers).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port alu_valid  input  1  ALU result offered.
REQ-006 The block SHALL have port alu_ready  output  1  ALU slot can accept.
REQ-007 The block SHALL have port alu_rd  input  ADDR_W  ALU destination register.
REQ-008 The block SHALL have port alu_data  input  DATA_W  ALU result.
REQ-009 The block SHALL have ports mem_valid, mem_ready, mem_rd and mem_data, identical in direction and width to the ALU ports, carrying load results.
REQ-010 The block SHALL have port load_enable  output  1  register-file write strobe, registered.
REQ-011 The block SHALL have port rc  output  ADDR_W  register-file write index, registered.
REQ-012 The block SHALL have port ry  output  DATA_W  register-file write data, registered.
REQ-013 The block SHALL have port wb_count  output  16  count of register writes issued.

Function
REQ-014 Each source SHALL own one holding slot (rd, data, full flag).
REQ-015 A transfer SHALL occur on a source when valid and ready are both 1 at a rising edge; the slot is full from the next cycle.
REQ-016 ready SHALL be 1 when the slot is empty or is being drained in the same cycle; it is combinational from slot state and arbiter grant only, never from valid.
REQ-017 valid high without ready SHALL hold the offer; rd and data SHALL be sampled only on transfer.
REQ-018 At most one slot SHALL be drained per cycle; a drained entry drives load_enable=1, rc=rd, ry=data after the next edge, otherwise load_enable=0 with rc/ry holding their last values.
REQ-019 Latency: transfer at edge N, load_enable high after edge N+1 (back-to-back bypass of an empty slot SHALL NOT occur).
REQ-020 The arbiter SHALL be a two-state FSM: MEM_PRI (reset state) grants mem when mem slot full, else alu; ALU_PRI grants alu when alu slot full, else mem.
REQ-021 A 2-bit starvation counter SHALL count cycles the alu slot is full and not granted; on reaching 2 the FSM moves to MEM_PRI->ALU_PRI; after one alu grant in ALU_PRI it returns to MEM_PRI and the counter clears.
REQ-022 Both slots full with equal rd: the first-granted entry SHALL be written first; the second write's value is final.
REQ-023 A slot drained and refilled in the same cycle SHALL keep full=1 with the new entry.
REQ-024 wb_count SHALL increment by 1 per load_enable pulse issued, wrapping 0xFFFF->0x0000.

Reset
REQ-025 With rst_n=0 at a rising edge: slots empty, FSM MEM_PRI, starvation counter 0, load_enable 0, rc 0, ry 0, wb_count 0.
REQ-026 While rst_n=0, alu_ready and mem_ready SHALL be 0; entries buffered when reset asserts mid-operation are discarded, not written.

Configuration
REQ-027 Macro WB_R0_DISCARD_EN defined: a granted entry with rd==0 SHALL be consumed (slot emptied, grant used) with load_enable=0 and wb_count unchanged.
REQ-028 WB_R0_DISCARD_EN undefined: rd==0 entries SHALL be written like any other register.

Verification
REQ-029 ALU only: alu_valid=1, rd=3, data=0x0000_00AA at edge N -> load_enable=1, rc=3, ry=0xAA after N+1; wb_count=1.
REQ-030 Simultaneous offers mem rd=4 data=0x11, alu rd=5 data=0x22 -> mem written first cycle, alu next; wb_count=2.
REQ-031 mem_valid held 1 continuously with alu slot full -> alu granted no later than third cycle after filling; FSM returns to MEM_PRI.
REQ-032 Slot full, source offering, no grant -> ready=0, data held, no transfer; entry with equal rd in both slots -> final write is the later grant.
REQ-033 rst_n=0 for one edge while both slots full -> no load_enable pulse, wb_count=0, readys 0 during reset, 1 the cycle after.
REQ-034 alu rd=0 data=0x55 -> with WB_R0_DISCARD_EN no pulse and wb_count unchanged; without it load_enable=1, rc=0, ry=0x55.
